// File: rtl/dm_pkg.sv
// Shared types and default widths for the burst memory controller.
// No logic here; the widths are defaults that instances may override.
// Not applicable: the package carries no flow control.
package dm_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;
  localparam int LW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

endpackage

// File: rtl/dat_mem.sv
// Single-address data store, 2^AW x DW, synchronous write, registered read.
// Latency: read data appears one cycle after re; writes land at the clock edge.
// No backpressure: we/re are honoured every cycle; rdata holds while re is low.
module dat_mem #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Array write; the array itself survives reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register: only the output stage is cleared, and it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_burst_ctrl.sv
// Burst load/store controller in front of a dat_mem array (1..4 beats per burst).
// Latency: load data 2 cycles after accept, one beat per cycle; store done 1 cycle after last beat.
// Backpressure: ready_o low while a burst runs; store beats stall on wr_valid_i without limit.
import dm_pkg::*;

module dm_burst_ctrl #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [LW-1:0] len_i,
  output logic          ready_o,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          done_o
);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [LW-1:0] cnt;
  logic          dir;
  logic          accept;
  logic          rd_beat;
  logic          wr_beat;
  logic          last_beat;
  logic          mem_we;

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave a burst only once the beat with cnt == 0 has happened.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i)                          state_nxt = we_i ? WR : RD;
      RD:      if (cnt == '0)                      state_nxt = IDLE;
      WR:      if (wr_valid_i && (cnt == '0))      state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // Outputs and beat strobes decoded from the current state.
  always_comb begin
    ready_o    = (state == IDLE);
    wr_ready_o = (state == WR);
    accept     = req_i & ready_o;
    rd_beat    = (state == RD);
    wr_beat    = wr_ready_o & wr_valid_i;
    last_beat  = (rd_beat | wr_beat) & (cnt == '0);
    mem_we     = wr_beat & dir;
  end

  // Burst pointer/count: load on accept, step on every beat; ptr wraps naturally.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      dir <= 1'b0;
    end else if (accept) begin
      ptr <= adr_i;
      cnt <= len_i;
      dir <= we_i;
    end else if (rd_beat || wr_beat) begin
      ptr <= ptr + 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Completion and read-valid trail the beat by one cycle, so they stay correct
  // even after the FSM has already returned to IDLE and taken a new request.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      rd_valid_o <= rd_beat;
      done_o     <= last_beat;
    end
  end

  dat_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk   (CLK),
    .rst   (reset),
    .we    (mem_we),
    .re    (rd_beat),
    .addr  (ptr),
    .wdata (wr_data_i),
    .rdata (rd_data_o)
  );

endmodule

// File: tb/tb_dm_burst_ctrl.sv
// Bench for dm_burst_ctrl: directed bursts plus random traffic against a memory model.
// Expected output events (cycle, data, done) are queued by the driver, popped by a monitor.
// Store beats are offered with random gaps to exercise wr_valid_i stalls.
module tb_dm_burst_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       req_i = 1'b0;
  logic       we_i = 1'b0;
  logic [7:0] adr_i = '0;
  logic [1:0] len_i = '0;
  logic       ready_o;
  logic [7:0] wr_data_i = '0;
  logic       wr_valid_i = 1'b0;
  logic       wr_ready_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       done_o;

  dm_burst_ctrl #(.DW(8), .AW(8), .LW(2)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .req_i      (req_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .len_i      (len_i),
    .ready_o    (ready_o),
    .wr_data_i  (wr_data_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .done_o     (done_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       rv;
    logic [7:0] dat;
    logic       dn;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mdl [256];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every active output cycle must match the head of the expectation queue.
  always @(negedge CLK) begin
    exp_t e;
    if (reset) begin
      last_rd = '0;
    end else begin
      if (!rd_valid_o) chk("rd_data_hold", {24'd0, rd_data_o}, {24'd0, last_rd});
      if (rd_valid_o || done_o) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: rv=%0b dn=%0b data=%0h at cycle %0d, nothing expected",
                   rd_valid_o, done_o, rd_data_o, cyc);
        end else begin
          e = expq.pop_front();
          if (cyc != e.cyc || rd_valid_o !== e.rv || done_o !== e.dn ||
              (e.rv && rd_data_o !== e.dat)) begin
            errors++;
            $display("FAIL output_event: got cyc=%0d rv=%0b dn=%0b data=%0h expected cyc=%0d rv=%0b dn=%0b data=%0h",
                     cyc, rd_valid_o, done_o, rd_data_o, e.cyc, e.rv, e.dn, e.dat);
          end
        end
      end
      if (rd_valid_o) last_rd = rd_data_o;
    end
  end

  // Raise a request and wait (bounded) for the cycle in which it is accepted.
  task automatic issue(input logic w, input logic [7:0] a, input logic [1:0] l, output int t);
    bit ok = 0;
    req_i = 1'b1;
    we_i  = w;
    adr_i = a;
    len_i = l;
    t = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (ready_o) begin
        ok = 1;
        t  = cyc;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_o never rose for adr %0h", a);
    end
  endtask

  // Load: data for beat i is the model contents, due at accept+2+i.
  task automatic do_load(input logic [7:0] a, input logic [1:0] l, input bit hold, output int t);
    exp_t e;
    issue(1'b0, a, l, t);
    for (int i = 0; i <= int'(l); i++) begin
      logic [7:0] ad;
      ad    = a + 8'(i);
      e.cyc = t + 2 + i;
      e.rv  = 1'b1;
      e.dat = mdl[ad];
      e.dn  = (i == int'(l));
      expq.push_back(e);
    end
    @(posedge CLK); #1;
    if (!hold) req_i = 1'b0;
  endtask

  // Store: gap[i] inserts an idle wr_valid_i cycle before beat i;
  // abort_at = i pulses reset instead of beat i.
  task automatic do_store(input logic [7:0] a, input logic [1:0] l, input logic [31:0] d,
                          input logic [3:0] gap, input int abort_at);
    int   t;
    int   b = 0;
    exp_t e;
    issue(1'b1, a, l, t);
    @(posedge CLK); #1;
    req_i = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      logic [7:0] ad;
      ad = a + 8'(i);
      if (i == abort_at) begin
        reset = 1'b1;
        wr_valid_i = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", {31'd0, ready_o}, 32'd1);
        @(posedge CLK); #1;
        return;
      end
      if (gap[i]) begin
        wr_valid_i = 1'b0;
        @(posedge CLK); #1;
      end
      wr_valid_i = 1'b1;
      wr_data_i  = d[8*i +: 8];
      @(negedge CLK);
      chk("wr_ready", {31'd0, wr_ready_o}, 32'd1);
      b = cyc;
      mdl[ad] = d[8*i +: 8];
      @(posedge CLK); #1;
      wr_valid_i = 1'b0;
    end
    e.cyc = b + 1;
    e.rv  = 1'b0;
    e.dat = '0;
    e.dn  = 1'b1;
    expq.push_back(e);
  endtask

  initial begin
    int t0, t1;
    // Reset state.
    @(negedge CLK);
    chk("rst_ready",    {31'd0, ready_o},    32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready_o}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_done",     {31'd0, done_o},     32'd0);
    chk("rst_rd_data",  {24'd0, rd_data_o},  32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;

    // Fill the whole array so every address has a known model value.
    for (int k = 0; k < 64; k++)
      do_store(8'(4*k), 2'd3, $urandom, 4'b0000, -1);

    // Store with one stall before the third beat, then read it back.
    do_store(8'd3, 2'd2, 32'h00332211, 4'b0100, -1);
    do_load(8'd3, 2'd2, 1'b0, t0);

    // Address wrap 254 -> 1.
    do_store(8'd254, 2'd3, 32'hA3A2A1A0, 4'b0000, -1);
    do_load(8'd254, 2'd3, 1'b0, t0);

    // Request held high through a load: next accept only when the first finishes.
    do_load(8'd4, 2'd3, 1'b1, t0);
    do_load(8'd10, 2'd1, 1'b0, t1);
    chk("held_req_accept_gap", t1 - t0, 32'd5);

    // Reset after the second of four beats: only two beats persist, no done.
    repeat (4) @(posedge CLK);
    #1;
    do_store(8'd64, 2'd3, 32'h44332211, 4'b0000, 2);
    do_load(8'd64, 2'd3, 1'b0, t0);

    // Random mix of bursts, with occasional back-to-back requests.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      logic [1:0] l;
      a = 8'($urandom);
      l = 2'($urandom);
      if ($urandom_range(1, 0) == 1)
        do_store(a, l, $urandom, 4'($urandom & 32'h5), -1);
      else
        do_load(a, l, 1'b0, t0);
      repeat ($urandom_range(1, 0)) @(posedge CLK);
      #1;
    end

    // Drain outstanding expectations.
    for (int k = 0; k < 30 && expq.size() != 0; k++) @(posedge CLK);
    @(negedge CLK);
    chk("queue_drained", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
